rgb2hsv: RTL and testbench

//  Converts one 24-bit RGB pixel to 8-bit-per-channel HSV, the inverse of the hsv2rgb colour path.

---
 rtl/rgb2hsv_pkg.sv | 39 +++
 rtl/rgb2hsv_seq_div16x8.sv | 61 ++++++
 rtl/rgb2hsv.sv | 155 +++++++++++++++
 tb/tb_rgb2hsv.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2hsv_pkg.sv
// Shared constants, state encoding and pixel field offsets for the HSV colour path.
// Both the rgb2hsv and hsv2rgb directions use these definitions.
package rgb2hsv_pkg;

  localparam int SECTOR    = 43;
  localparam int HUE_G     = 2 * SECTOR - 1;
  localparam int HUE_B     = 4 * SECTOR - 1;
  localparam int DIV_STEPS = 16;

  // {R,B,G} input packing matches the hsv2rgb output
  localparam int R_LSB = 16;
  localparam int B_LSB = 8;
  localparam int G_LSB = 0;
  localparam int H_LSB = 16;
  localparam int S_LSB = 8;
  localparam int V_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SORT  = 3'd1,
    DIV_S = 3'd2,
    DIV_H = 3'd3,
    DONE  = 3'd4
  } stateT;

  typedef enum logic [1:0] {
    MAX_R = 2'd0,
    MAX_G = 2'd1,
    MAX_B = 2'd2
  } maxSelT;

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

endpackage

// File: rtl/rgb2hsv_seq_div16x8.sv
// Restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per cycle.
// done pulses once, 16 cycles after an accepted start; start while busy is ignored.
module seq_div16x8
  import rgb2hsv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic        done
);

  logic [15:0] quo;
  logic [7:0]  rem;
  logic [7:0]  divReg;
  logic [4:0]  cnt;
  logic        busy;
  logic [8:0]  shifted;
  logic        fits;
  logic [7:0]  diff;

  // Remainder stays below the divisor, so the shifted value needs only 9 bits
  always_comb begin
    shifted = {rem, quo[15]};
    fits    = shifted >= {1'b0, divReg};
    diff    = shifted[7:0] - divReg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo    <= '0;
      rem    <= '0;
      divReg <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        quo <= {quo[14:0], fits};
        rem <= fits ? diff : shifted[7:0];
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        quo    <= dividend;
        rem    <= '0;
        divReg <= divisor;
        cnt    <= 5'(DIV_STEPS);
        busy   <= 1'b1;
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/rgb2hsv.sv
// Iterative RGB to HSV converter, one pixel in flight, valid/ready on both sides.
// Hue uses 43 codes per 60-degree sector and wraps modulo 256.
//
// state | meaning
// IDLE  | in_ready high, waiting for a pixel
// SORT  | find max/min/delta; achromatic pixels finish here
// DIV_S | S = 255*delta/max on the shared divider
// DIV_H | q = 43*|d|/delta, hue = base +/- q
// DONE  | out_valid held until out_ready
module rgb2hsv
  import rgb2hsv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_rgb,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_hsv,
  output logic        out_valid,
  input  logic        out_ready
);

  stateT state, nextState;

  logic [7:0] rReg, gReg, bReg;
  maxSelT     sel, selReg;
  logic [7:0] maxV, minV, delta, absD;
  logic       dNeg;
  logic [7:0] maxReg, deltaReg, absDReg, satReg;
  logic       dNegReg;

  logic        divStart, divDone;
  logic [15:0] divDividend, divQuo;
  logic [7:0]  divDivisor;
  logic [7:0]  hueBase, q, hue;
  logic        unusedQuoHi;

  // Max selection: R wins ties, then G
  always_comb begin
    sel  = MAX_B;
    maxV = bReg;
    absD = (rReg >= gReg) ? rReg - gReg : gReg - rReg;
    dNeg = rReg < gReg;
    if (rReg >= gReg && rReg >= bReg) begin
      sel  = MAX_R;
      maxV = rReg;
      absD = (gReg >= bReg) ? gReg - bReg : bReg - gReg;
      dNeg = gReg < bReg;
    end else if (gReg >= bReg) begin
      sel  = MAX_G;
      maxV = gReg;
      absD = (bReg >= rReg) ? bReg - rReg : rReg - bReg;
      dNeg = bReg < rReg;
    end
    minV  = min3(rReg, gReg, bReg);
    delta = maxV - minV;
  end

  always_comb begin
    if (state == SORT) begin
      divDividend = 16'(delta) * 16'd255;
      divDivisor  = maxV;
    end else begin
      divDividend = 16'(absDReg) * 16'(SECTOR);
      divDivisor  = deltaReg;
    end
  end

  seq_div16x8 uDiv (
    .clk      (clk),
    .reset    (reset),
    .start    (divStart),
    .dividend (divDividend),
    .divisor  (divDivisor),
    .quotient (divQuo),
    .done     (divDone)
  );

  assign unusedQuoHi = ^divQuo[15:8];
  assign q           = divQuo[7:0];

  always_comb begin
    unique case (selReg)
      MAX_G:   hueBase = 8'(HUE_G);
      MAX_B:   hueBase = 8'(HUE_B);
      default: hueBase = 8'd0;
    endcase
    hue = dNegReg ? hueBase - q : hueBase + q;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (in_valid) nextState = SORT;
      SORT:    nextState = (delta == 8'd0) ? DONE : DIV_S;
      DIV_S:   if (divDone) nextState = DIV_H;
      DIV_H:   if (divDone) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    divStart = ((state == SORT) && (delta != 8'd0)) || ((state == DIV_S) && divDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rReg      <= '0;
      gReg      <= '0;
      bReg      <= '0;
      selReg    <= MAX_R;
      maxReg    <= '0;
      deltaReg  <= '0;
      absDReg   <= '0;
      dNegReg   <= 1'b0;
      satReg    <= '0;
      out_hsv   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          rReg <= in_rgb[R_LSB +: 8];
          gReg <= in_rgb[G_LSB +: 8];
          bReg <= in_rgb[B_LSB +: 8];
        end
        SORT: begin
          selReg   <= sel;
          maxReg   <= maxV;
          deltaReg <= delta;
          absDReg  <= absD;
          dNegReg  <= dNeg;
          if (delta == 8'd0) begin
            out_hsv   <= {8'd0, 8'd0, maxV};
            out_valid <= 1'b1;
          end
        end
        DIV_S: if (divDone) satReg <= q;
        DIV_H: if (divDone) begin
          out_hsv   <= {hue, satReg, maxReg};
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2hsv.sv
// Scoreboard bench for rgb2hsv: directed corner pixels plus a randomised sweep
// against a floor-arithmetic HSV model.
module tb_rgb2hsv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] in_rgb = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] out_hsv;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int nChecks = 0;
  int nFails  = 0;

  logic [23:0] expQ[$];
  bit          pending = 0;
  bit          valSeen = 1;
  int          negCnt = 0;
  int          acceptNeg = 0;
  int          expLat = 0;
  bit          prevValid = 0;
  bit          prevReady = 0;
  logic [23:0] prevHsv = '0;

  bit randReady  = 0;
  bit fixedReady = 1;

  rgb2hsv dut (
    .clk       (clk),
    .reset     (reset),
    .in_rgb    (in_rgb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_hsv   (out_hsv),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] refHsv(input int r, input int g, input int b);
    int mx, mn, dl, d, base, s, qq, h;
    if (r >= g && r >= b) begin mx = r; d = g - b; base = 0; end
    else if (g >= b)      begin mx = g; d = b - r; base = 85; end
    else                  begin mx = b; d = r - g; base = 171; end
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    dl = mx - mn;
    if (dl == 0) return {16'd0, 8'(mx)};
    s  = (255 * dl) / mx;
    qq = (43 * ((d < 0) ? -d : d)) / dl;
    h  = base + ((d < 0) ? -qq : qq);
    h  = ((h % 256) + 256) % 256;
    return {8'(h), 8'(s), 8'(mx)};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    int r, g, b;
    logic [23:0] e;
    negCnt++;
    if (reset) begin
      pending   = 0;
      valSeen   = 1;
      prevValid = 0;
      expQ.delete();
    end else begin
      check("in_ready_vs_busy", 32'(in_ready), 32'(!pending));
      if (out_valid && prevValid && !prevReady)
        check("out_hsv_hold_stable", 32'(out_hsv), 32'(prevHsv));
      if (out_valid && !valSeen) begin
        valSeen = 1;
        check("latency", 32'(negCnt - acceptNeg - 1), 32'(expLat));
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", out_hsv);
        end else begin
          e = expQ.pop_front();
          check("pixel_hsv", 32'(out_hsv), 32'(e));
        end
        pending = 0;
      end
      if (in_valid && in_ready) begin
        r = int'(in_rgb[23:16]);
        b = int'(in_rgb[15:8]);
        g = int'(in_rgb[7:0]);
        pending   = 1;
        valSeen   = 0;
        acceptNeg = negCnt;
        expLat    = (r == g && g == b) ? 1 : 35;
        expQ.push_back(refHsv(r, g, b));
      end
      prevValid = out_valid;
      prevReady = out_ready;
      prevHsv   = out_hsv;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = randReady ? ($urandom_range(0, 3) != 0) : fixedReady;
    end
  end

  task automatic sendPixel(input int r, input int g, input int b);
    int n;
    @(posedge clk);
    #1;
    in_rgb   = {8'(r), 8'(b), 8'(g)};
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n >= 200), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((pending || expQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= 300), 32'd0);
  endtask

  task automatic waitOutValid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", 32'(n >= 100), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, b, mode;
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_hsv", 32'(out_hsv), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Primaries, greys, wrap and tie
    sendPixel(255, 0, 0);     waitIdle();
    sendPixel(0, 255, 0);     waitIdle();
    sendPixel(0, 0, 255);     waitIdle();
    sendPixel(128, 128, 128); waitIdle();
    sendPixel(0, 0, 0);       waitIdle();
    sendPixel(255, 0, 128);   waitIdle();
    sendPixel(255, 255, 0);   waitIdle();

    // Back-pressure in DONE with a pending input
    fixedReady = 0;
    sendPixel(10, 200, 90);
    waitOutValid();
    @(posedge clk);
    #1;
    in_rgb   = {8'd40, 8'd30, 8'd250};
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    fixedReady = 1;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("release_timeout", 32'(n >= 20), 32'd0);
    @(negedge clk);
    check("release_in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("release_next_accepted", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitIdle();

    // Reset while dividing for saturation
    sendPixel(200, 50, 100);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    sendPixel(30, 60, 90); waitIdle();

    // Random sweep with random valid gaps and back-pressure
    randReady = 1;
    for (int i = 0; i < 1000; i++) begin
      mode = $urandom_range(0, 7);
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (mode == 0) begin g = r; b = r; end
      else if (mode == 1) begin g = r; end
      else if (mode == 2) begin b = g; end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      sendPixel(r, g, b);
    end
    waitIdle();
    randReady = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
